// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and status controller for a circular-buffer FIFO built on a
// dual-port register file (synchronous write port, combinational read port).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   wr           write request (data presented to the register file this cycle)
//   rd           read request (pops the word at r_addr)
//   clr_err      clears the sticky overflow/underflow flags
//   w_en         register-file write enable (combinational)
//   w_addr       register-file write address (write pointer)
//   r_addr       register-file read address (read pointer)
//   full         count == depth
//   empty        count == 0
//   almost_full  count >= af_level
//   count        occupancy, 0..depth
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was attempted on empty
module fifo_ctrl #(
   parameter int unsigned addr_width = 4,
   parameter int unsigned af_level   = (1 << addr_width) - 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr,
   input  logic                  rd,
   input  logic                  clr_err,
   output logic                  w_en,
   output logic [addr_width-1:0] w_addr,
   output logic [addr_width-1:0] r_addr,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [addr_width:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned depth = 1 << addr_width;
   localparam int unsigned cnt_w = addr_width + 1;

   logic             do_wr;
   logic             do_rd;
   logic [cnt_w-1:0] count_nxt;

   // A write into a full FIFO is still accepted when a read frees a slot at the same edge.
   assign do_wr = wr & (~full | rd);
   assign do_rd = rd & ~empty;
   assign w_en  = do_wr;

   // Next occupancy; flags are derived from it so they are registered, not combinational.
   always_comb begin
      count_nxt = count;
      if (do_wr && !do_rd) begin
         count_nxt = count + cnt_w'(1);
      end else if (do_rd && !do_wr) begin
         count_nxt = count - cnt_w'(1);
      end
   end

   // Pointer, occupancy and status registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_addr      <= '0;
         r_addr      <= '0;
         count       <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         if (do_wr) begin
            w_addr <= w_addr + addr_width'(1);
         end
         if (do_rd) begin
            r_addr <= r_addr + addr_width'(1);
         end
         count       <= count_nxt;
         full        <= (count_nxt == cnt_w'(depth));
         empty       <= (count_nxt == '0);
         almost_full <= (count_nxt >= cnt_w'(af_level));
         // A new error in the same cycle as clr_err keeps the flag set.
         overflow    <= (wr & ~do_wr) | (overflow & ~clr_err);
         underflow   <= (rd & empty) | (underflow & ~clr_err);
      end
   end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and status controller for the UART TX/RX FIFOs. It sequences a dual-port register file (one synchronous write port, one combinational read port) as a circular buffer. It generates the write enable, write address and read address, and exposes full, empty, occupancy and error status to the UART core and the bus interface.

## Interface

Parameters:
- addr_width, 4, address bits; depth = 2**addr_width entries.
- af_level, 2**addr_width-2, almost_full threshold in entries; legal range 1..2**addr_width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr  input  1  write request; data is presented to the register file in the same cycle.
- rd  input  1  read request; pops the word currently at r_addr.
- clr_err  input  1  clears the sticky error flags.
- w_en  output  1  register-file write enable (combinational).
- w_addr  output  addr_width  register-file write address (registered write pointer).
- r_addr  output  addr_width  register-file read address (registered read pointer).
- full  output  1  registered; count == depth.
- empty  output  1  registered; count == 0.
- almost_full  output  1  registered; count >= af_level.
- count  output  addr_width+1  registered occupancy, 0..depth.
- overflow  output  1  sticky; a write was dropped.
- underflow  output  1  sticky; a read was attempted on empty.

## Operation

- State: write pointer wp, read pointer rp (addr_width bits, natural wrap at depth-1 -> 0), count, full, empty, almost_full, overflow, underflow.
- Reset, asynchronous: wp=0, rp=0, count=0, empty=1, full=0, almost_full=0 (if af_level>0), overflow=0, underflow=0.
- Accept conditions per cycle:
  - do_wr = wr & (~full | rd)
  - do_rd = rd & ~empty
- w_en = do_wr. It is combinational from wr, rd and full; no other path asserts it.
- Transitions, applied on the clock edge:
  - do_wr only: wp+1, count+1.
  - do_rd only: rp+1, count-1.
  - both: wp+1, rp+1, count unchanged.
  - neither: hold.
- full, empty and almost_full are computed from next count and registered. No combinational path runs from wr/rd to these flags.
- Boundary cases:
  - wr & ~rd while full: write dropped, w_en=0, overflow set.
  - rd while empty: no pop, rp held, underflow set. If wr is also high, the write proceeds: count 0->1, empty deasserts next cycle, and underflow is still set.
  - wr & rd while full: both accepted. The read sees the old word because the read port is combinational and the write lands at the edge; full stays 1.
  - Pointer wrap: depth-1 -> 0 with no gap. full/empty disambiguation uses count, not pointer equality.
- Sticky flags:
  - clr_err clears overflow/underflow on the next edge.
  - If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.
- Reset mid-operation: all state returns to reset values immediately. Register-file contents are not cleared and are treated as stale.

## Timing

- Write latency: a word written at edge N is readable at r_addr/r_data after edge N; empty falls after edge N.
- Read: r_data is valid combinationally while ~empty; rd advances rp at the next edge.
- Flag latency: flags reflect the accepted operation one cycle after the request.
- Throughput: one write and one read per cycle, sustained.

## Test plan

- Reset then idle: empty=1, full=0, count=0, w_addr=r_addr=0, w_en=0; assert reset mid-stream with count=5 -> all outputs return to reset values asynchronously.
- Fill depth=16 with 16 writes -> count=16, full=1, almost_full asserted from count=14; 17th write -> w_en=0, count=16, overflow=1; then clr_err -> overflow=0.
- Drain 16 reads after fill -> r_addr walks 0..15, empty=1 after the 16th read; 17th read -> r_addr held, underflow=1.
- Pointer wrap: 10 writes, 10 reads, then 10 writes -> w_addr goes 15->0 at write 16 total, count=10, no error flags.
- Simultaneous wr & rd:
  - at count=16: w_en=1, both pointers advance, full stays 1, count=16.
  - at count=0: write accepted, count=1, underflow=1.
- clr_err in the same cycle as a dropped write -> overflow stays 1.
